// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree walker.
// It holds the field positions of the 36-bit node word, the index and word widths, and the walker state encoding.
// It has no ports.
package dt_pkg;

  localparam int NODE_W     = 36;
  localparam int NODE_IDX_W = 9;
  localparam int DEPTH_W    = 5;

  // Node word fields
  localparam int LEAF_BIT = 35;
  localparam int FIDX_MSB = 34;
  localparam int FIDX_LSB = 30;
  localparam int THR_MSB  = 29;
  localparam int THR_LSB  = 14;
  localparam int LEFT_MSB = 13;
  localparam int LEFT_LSB = 5;

  localparam int FIDX_W = FIDX_MSB - FIDX_LSB + 1;
  localparam int THR_W  = THR_MSB - THR_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/dt_node_eval.sv
// Combinational decode of one node word against the latched feature vector.
// Ports: all_info and features come in. The outputs are is_leaf, leaf_class, next_idx (the chosen child),
//        idx_err (feature index out of range) and ovf_err (right child would pass index 511).
module dt_node_eval
  import dt_pkg::*;
#(
  parameter int N_FEAT  = 16,
  parameter int FEAT_W  = 16,
  parameter int CLASS_W = 4
) (
  input  logic [NODE_W-1:0]        all_info,
  input  logic [N_FEAT*FEAT_W-1:0] features,
  output logic                     is_leaf,
  output logic [CLASS_W-1:0]       leaf_class,
  output logic [NODE_IDX_W-1:0]    next_idx,
  output logic                     idx_err,
  output logic                     ovf_err
);

  logic [FIDX_W-1:0]     fidx;
  logic [THR_W-1:0]      thr;
  logic [NODE_IDX_W-1:0] left;
  logic [FEAT_W-1:0]     feat;
  logic                  go_left;

  assign is_leaf    = all_info[LEAF_BIT];
  assign leaf_class = all_info[CLASS_W-1:0];
  assign fidx       = all_info[FIDX_MSB:FIDX_LSB];
  assign thr        = all_info[THR_MSB:THR_LSB];
  assign left       = all_info[LEFT_MSB:LEFT_LSB];

  assign idx_err = !is_leaf && (int'(fidx) >= N_FEAT);

  // The mux is written as a loop so that an out-of-range index never forms an out-of-bounds part-select.
  always_comb begin
    feat = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (int'(fidx) == k) feat = features[k*FEAT_W +: FEAT_W];
    end
  end

  assign go_left  = feat < thr;
  assign next_idx = go_left ? left : left + 1'b1;
  assign ovf_err  = !is_leaf && !idx_err && !go_left && (left == '1);

  // Bits between the class field and the left-child field carry no meaning in either node kind.
  generate
    if (CLASS_W < LEFT_LSB) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^all_info[LEFT_LSB-1:CLASS_W];
    end
  endgenerate

endmodule

// File: rtl/dt_walker.sv
// Walks one decision tree from the root to a leaf through a fixed-latency node ROM.
// Ports: an in_valid/in_ready feature input; node_idx out to the ROM and all_info back from it;
//        an out_valid/out_ready result carrying out_class, out_err and out_depth. Reset is synchronous on rst.
module dt_walker
  import dt_pkg::*;
#(
  parameter int                    N_FEAT    = 16,
  parameter int                    FEAT_W    = 16,
  parameter int                    CLASS_W   = 4,
  parameter int                    ROM_LAT   = 3,
  parameter int                    MAX_DEPTH = 16,
  parameter logic [NODE_IDX_W-1:0] ROOT      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_features,
  output logic [NODE_IDX_W-1:0]    node_idx,
  input  logic [NODE_W-1:0]        all_info,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  output logic [DEPTH_W-1:0]       out_depth
);

  // WAIT counts down from ROM_LAT-1. all_info is captured at the ROM_LAT-th edge after node_idx moves.
  // That same edge enters EVAL, so each node takes ROM_LAT+1 cycles.
  localparam int               CNT_W    = $clog2(ROM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);

  state_e                  state_q, state_d;
  logic [NODE_IDX_W-1:0]   node_q, node_d;
  logic [DEPTH_W-1:0]      depth_q, depth_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CLASS_W-1:0]      class_q, class_d;
  logic                    err_q, err_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q;
  logic [NODE_W-1:0]       info_q;
  logic                    feat_load, info_load;

  logic                    is_leaf, idx_err, ovf_err;
  logic [CLASS_W-1:0]      leaf_class;
  logic [NODE_IDX_W-1:0]   next_idx;

  dt_node_eval #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .CLASS_W(CLASS_W)
  ) u_eval (
    .all_info  (info_q),
    .features  (feat_q),
    .is_leaf   (is_leaf),
    .leaf_class(leaf_class),
    .next_idx  (next_idx),
    .idx_err   (idx_err),
    .ovf_err   (ovf_err)
  );

  always_comb begin
    state_d   = state_q;
    node_d    = node_q;
    depth_d   = depth_q;
    cnt_d     = cnt_q;
    class_d   = class_q;
    err_d     = err_q;
    feat_load = 1'b0;
    info_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          feat_load = 1'b1;
          node_d    = ROOT;
          depth_d   = '0;
          cnt_d     = CNT_LOAD;
          class_d   = '0;
          err_d     = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          info_load = 1'b1;
          state_d   = EVAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EVAL: begin
        if (is_leaf) begin
          class_d = leaf_class;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (idx_err || ovf_err || (int'(depth_q) + 1 == MAX_DEPTH)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          node_d  = next_idx;
          depth_d = depth_q + 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      node_q  <= ROOT;
      depth_q <= '0;
      cnt_q   <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Datapath latches carry no reset. They are only read after a fresh load.
  always_ff @(posedge clk) begin
    if (feat_load) feat_q <= in_features;
    if (info_load) info_q <= all_info;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign node_idx  = node_q;
  assign out_class = class_q;
  assign out_err   = err_q;
  assign out_depth = depth_q;

endmodule

// File: tb/tb_dt_walker.sv
module tb_dt_walker;

  localparam int N_FEAT = 16, FEAT_W = 16, CLASS_W = 4, ROM_LAT = 3, MAX_DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_features = '0;
  logic [8:0]   node_idx;
  logic [35:0]  all_info = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   out_class;
  logic         out_err;
  logic [4:0]   out_depth;

  always #5 clk = ~clk;

  dt_walker #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
    .ROM_LAT(ROM_LAT), .MAX_DEPTH(MAX_DEPTH), .ROOT(9'd0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .node_idx(node_idx), .all_info(all_info),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_depth(out_depth)
  );

  // ROM model. node_idx is registered in the walker, so two further stages make the word
  // ready for capture at the third edge after node_idx changes (ROM_LAT = 3).
  logic [35:0] mem [512];
  logic [35:0] rom_s1 = '0;
  always @(posedge clk) begin
    rom_s1   <= mem[node_idx];
    all_info <= rom_s1;
  end

  int checks = 0;
  int errors = 0;
  logic [8:0] nid [0:127];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [35:0] leaf(input int c);
    return {1'b1, 31'b0, 4'(c)};
  endfunction

  function automatic logic [35:0] inode(input int f, input int thr, input int left);
    return {1'b0, 5'(f), 16'(thr), 9'(left), 5'b0};
  endfunction

  function automatic logic [255:0] rnd_feat();
    logic [255:0] f;
    for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = leaf(0);
  endtask

  // Golden tree walk used for the random traffic.
  function automatic void model(input logic [255:0] f, output int cls, output int dep, output int err);
    int idx = 0;
    logic [35:0] w;
    logic [9:0]  nxt;
    int fi;
    cls = 0; dep = 0; err = 0;
    for (int it = 0; it < 64; it++) begin
      w = mem[idx];
      if (w[35]) begin cls = int'(w[3:0]); return; end
      fi = int'(w[34:30]);
      if (fi >= N_FEAT) begin err = 1; return; end
      nxt = (f[fi*16 +: 16] < w[29:14]) ? {1'b0, w[13:5]} : {1'b0, w[13:5]} + 10'd1;
      if (nxt == 10'd512 || dep + 1 == MAX_DEPTH) begin err = 1; return; end
      dep++;
      idx = int'(nxt);
    end
  endfunction

  task automatic send(input logic [255:0] f);
    int n = 0;
    @(negedge clk);
    in_features = f;
    in_valid    = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_features = rnd_feat();
  endtask

  // Cycle k is the k-th cycle after the accept edge. lat is the first k with out_valid high.
  task automatic recv(input bit rand_rdy, output int cls, output int err, output int dep, output int lat);
    int  k = 0;
    bit  got = 0;
    cls = -1; err = -1; dep = -1; lat = 0;
    while (!got && k < 120) begin
      @(negedge clk);
      k++;
      nid[k] = node_idx;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && lat == 0) lat = k;
      if (out_valid && out_ready) begin
        cls = int'(out_class); err = int'(out_err); dep = int'(out_depth);
        got = 1;
      end
    end
    chk("result_seen", got, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after_done", in_ready, 1);
  endtask

  typedef struct {
    logic [15:0] f2;
    int          cls;
    int          child;
  } tl_vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tl_vec_t      tv [5];
    logic [255:0] f;
    int           cls, err, dep, lat, e_cls, e_dep, e_err, n;

    tv[0] = '{16'd99,     3, 1};
    tv[1] = '{16'd100,    7, 2};
    tv[2] = '{16'd0,      3, 1};
    tv[3] = '{16'hFFFF,   7, 2};
    tv[4] = '{16'd101,    7, 2};

    clear_mem();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_node_idx", node_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_depth", out_depth, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Root is a leaf
    mem[0] = leaf(5);
    send(rnd_feat());
    recv(0, cls, err, dep, lat);
    chk("rootleaf_class", cls, 5);
    chk("rootleaf_err", err, 0);
    chk("rootleaf_depth", dep, 0);
    chk("rootleaf_latency", lat, ROM_LAT + 2);

    // Two-level tree, table driven
    mem[0] = inode(2, 100, 1);
    mem[1] = leaf(3);
    mem[2] = leaf(7);
    for (int i = 0; i < 5; i++) begin
      f = rnd_feat();
      f[2*16 +: 16] = tv[i].f2;
      send(f);
      recv(0, cls, err, dep, lat);
      chk("tl_class", cls, tv[i].cls);
      chk("tl_err", err, 0);
      chk("tl_depth", dep, 1);
      chk("tl_latency", lat, 2 * (ROM_LAT + 1) + 1);
      for (int c = 1; c <= 4; c++) chk("tl_nid_root", nid[c], 0);
      for (int c = 5; c <= 8; c++) chk("tl_nid_child", nid[c], tv[i].child);
    end

    // Backpressure: result held while out_ready is low
    f = rnd_feat();
    f[2*16 +: 16] = 16'd50;
    send(f);
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk("bp_valid_seen", out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_class_hold", out_class, 3);
      chk("bp_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready_next", in_ready, 1);

    // Feature index out of range
    mem[0] = inode(20, 100, 1);
    send(rnd_feat());
    recv(0, cls, err, dep, lat);
    chk("fidx_err", err, 1);
    chk("fidx_class", cls, 0);
    chk("fidx_depth", dep, 0);

    // Self-loop hits the depth limit
    mem[0] = inode(0, 16'hFFFF, 0);
    f = rnd_feat();
    f[15:0] = 16'd0;
    send(f);
    recv(0, cls, err, dep, lat);
    chk("loop_err", err, 1);
    chk("loop_class", cls, 0);
    chk("loop_depth", dep, MAX_DEPTH - 1);
    chk("loop_latency", lat, MAX_DEPTH * (ROM_LAT + 1) + 1);

    // Left child 511: right branch overflows, left branch is legal
    mem[0]   = inode(1, 10, 511);
    mem[511] = leaf(9);
    f = rnd_feat();
    f[16 +: 16] = 16'd500;
    send(f);
    recv(0, cls, err, dep, lat);
    chk("ovf_err", err, 1);
    chk("ovf_class", cls, 0);
    f[16 +: 16] = 16'd5;
    send(f);
    recv(0, cls, err, dep, lat);
    chk("left511_err", err, 0);
    chk("left511_class", cls, 9);
    chk("left511_depth", dep, 1);

    // Reset while waiting on the second node
    clear_mem();
    mem[0] = inode(2, 100, 1);
    mem[1] = leaf(3);
    mem[2] = leaf(7);
    f = rnd_feat();
    f[2*16 +: 16] = 16'd99;
    send(f);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_node_before", node_idx, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_node_idx", node_idx, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready_low", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("midrst_no_result", n, 0);
    out_ready = 1'b0;
    f[2*16 +: 16] = 16'd100;
    send(f);
    recv(0, cls, err, dep, lat);
    chk("midrst_next_class", cls, 7);
    chk("midrst_next_depth", dep, 1);

    // Random traffic against the golden walk
    clear_mem();
    mem[0] = inode(0, 16'h8000, 1);
    mem[1] = inode(3, 16'h4000, 3);
    mem[2] = inode(7, 16'hC000, 5);
    mem[3] = leaf(1);
    mem[4] = leaf(2);
    mem[5] = leaf(3);
    mem[6] = leaf(4);
    for (int i = 0; i < 100; i++) begin
      f = rnd_feat();
      model(f, e_cls, e_dep, e_err);
      send(f);
      recv(1, cls, err, dep, lat);
      chk("rand_class", cls, e_cls);
      chk("rand_depth", dep, e_dep);
      chk("rand_err", err, e_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
